// File: rtl/frame_sequencer.sv
// frame_sequencer -- drives one game frame as four steps: erase, physics update,
// draw, then an inter-frame wait. Each engine gets a one-cycle start pulse and
// returns a done strobe. The wait lasts DELAY_CYCLES cycles. frame_tick pulses
// in the last cycle of the wait, and frame_count counts completed frames.
//
// Parameters:
//   DELAY_CYCLES  wait length in clock cycles (1 .. 2^25-1)
//   FC_W          frame counter width
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    synchronous, active-high
//   enable                   game running (level)
//   pause                    freezes the frame wait (only with FRAME_SEQ_PAUSE_EN)
//   erase_done/update_done/draw_done     engine completion strobes
//   erase_start/update_start/draw_start  registered single-cycle start pulses
//   frame_tick               pulse in the final cycle of the wait
//   busy                     state != IDLE
//   state                    IDLE=0 ERASE=1 UPDATE=2 DRAW=3 WAIT=4
//   frame_count              completed frames, wraps modulo 2^FC_W
//
// Build option: define FRAME_SEQ_PAUSE_EN to add the pause port and its hold logic.

module frame_sequencer #(
  parameter logic [24:0] DELAY_CYCLES = 25'd5000000,
  parameter int unsigned FC_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
`ifdef FRAME_SEQ_PAUSE_EN
  input  logic            pause,
`endif
  input  logic            erase_done,
  input  logic            update_done,
  input  logic            draw_done,
  output logic            erase_start,
  output logic            update_start,
  output logic            draw_start,
  output logic            frame_tick,
  output logic            busy,
  output logic [2:0]      state,
  output logic [FC_W-1:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_UPDATE = 3'd2,
    S_DRAW   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  localparam logic [24:0] LP_LAST = DELAY_CYCLES - 25'd1;

  state_t          r_state;
  state_t          w_next;
  logic            r_erase_start;
  logic            r_update_start;
  logic            r_draw_start;
  logic [24:0]     r_cnt;
  logic [FC_W-1:0] r_fc;
  logic            w_pause;
  logic            w_wait_end;

`ifdef FRAME_SEQ_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Last cycle of the wait. A paused wait never reaches its end.
  assign w_wait_end = (r_state == S_WAIT) && (r_cnt == LP_LAST) && !w_pause;

  // State register and registered start pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_erase_start  <= 1'b0;
      r_update_start <= 1'b0;
      r_draw_start   <= 1'b0;
      r_cnt          <= '0;
      r_fc           <= '0;
    end else begin
      r_state        <= w_next;
      r_erase_start  <= (w_next == S_ERASE)  && (r_state != S_ERASE);
      r_update_start <= (w_next == S_UPDATE) && (r_state != S_UPDATE);
      r_draw_start   <= (w_next == S_DRAW)   && (r_state != S_DRAW);
      if ((r_state == S_DRAW) && (w_next == S_WAIT))
        r_cnt <= '0;
      else if ((r_state == S_WAIT) && !w_pause && !w_wait_end)
        r_cnt <= r_cnt + 25'd1;
      if (w_wait_end)
        r_fc <= r_fc + FC_W'(1);
    end
  end

  // Next-state logic. The start pulse is high only in the first cycle of a
  // phase, so a done strobe that arrives together with the start is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_ERASE;
      S_ERASE:  if (erase_done  && !r_erase_start)  w_next = S_UPDATE;
      S_UPDATE: if (update_done && !r_update_start) w_next = S_DRAW;
      S_DRAW:   if (draw_done   && !r_draw_start)   w_next = S_WAIT;
      S_WAIT:   if (w_wait_end) w_next = enable ? S_ERASE : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    erase_start  = r_erase_start;
    update_start = r_update_start;
    draw_start   = r_draw_start;
    frame_tick   = w_wait_end;
    busy         = (r_state != S_IDLE);
    state        = r_state;
    frame_count  = r_fc;
  end

endmodule
